dmem_bridge: RTL

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: adapts a core data-memory port (byte/half/word, sign/zero
// extending loads) onto a word-wide valid/ready bus with byte enables.
// Misaligned and illegal-size accesses fault without touching the bus. A
// wait counter bounds every access and forces a fault on timeout.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   dmem_req             core access request, held while dmem_busy=1
//   dmem_wr_en           1=store, 0=load
//   dmem_size            2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 illegal
//   dmem_zero_extend     load extension: 1=zero, 0=sign
//   dmem_addr            byte address
//   dmem_wr_data         right-aligned store data
//   dmem_rd_data         extended load data, non-zero only in DONE
//   dmem_busy            core stall (combinational)
//   dmem_fault           one-cycle fault pulse in DONE
//   bus_valid/bus_ready  bus request handshake
//   bus_we, bus_addr     bus write flag, word-aligned address
//   bus_be, bus_wdata    byte enables, lane-replicated write data
//   bus_rvalid/bus_rdata read data return
//   bus_err              error, sampled with bus_ready (store) or bus_rvalid (load)
module dmem_bridge #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req,
  input  logic        dmem_wr_en,
  input  logic [1:0]  dmem_size,
  input  logic        dmem_zero_extend,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  output logic [31:0] dmem_rd_data,
  output logic        dmem_busy,
  output logic        dmem_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, RDATA, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            zext_q, zext_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic            valid_q;
  logic            legal_c;
  logic            timeout_c;

  // Shift the returned word down to the addressed lane, then extend.
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                input logic [1:0]    off,
                                                input logic [1:0]    sz,
                                                input logic          zx);
    logic [DW-1:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: load_extend = zx ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = zx ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Alignment and size legality of the presented request.
  always_comb begin
    legal_c = 1'b0;
    case (dmem_size)
      SZ_BYTE: legal_c = 1'b1;
      SZ_HALF: legal_c = ~dmem_addr[0];
      SZ_WORD: legal_c = (dmem_addr[1:0] == 2'b00);
      default: legal_c = 1'b0;
    endcase
  end

  // The counter value this cycle would reach TIMEOUT_CYCLES after incrementing.
  assign timeout_c = ((9'(cnt_q) + 9'd1) == 9'(TIMEOUT_CYCLES));

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    zext_d  = zext_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    rd_d    = '0;

    case (state_q)
      IDLE: begin
        if (dmem_req) begin
          if (legal_c) begin
            addr_d  = dmem_addr;
            size_d  = dmem_size;
            zext_d  = dmem_zero_extend;
            we_d    = dmem_wr_en;
            cnt_d   = '0;
            case (dmem_size)
              SZ_BYTE: begin
                be_d    = 4'b0001 << dmem_addr[1:0];
                wdata_d = {4{dmem_wr_data[7:0]}};
              end
              SZ_HALF: begin
                be_d    = 4'b0011 << dmem_addr[1:0];
                wdata_d = {2{dmem_wr_data[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = dmem_wr_data;
              end
            endcase
            state_d = ADDR;
          end else begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      ADDR: begin
        cnt_d = cnt_q + 8'd1;
        // bus_ready takes priority over a same-cycle timeout.
        if (bus_ready) begin
          if (we_q) begin
            fault_d = bus_err;
            state_d = DONE;
          end else begin
            state_d = RDATA;
          end
        end else if (timeout_c) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end

      RDATA: begin
        cnt_d = cnt_q + 8'd1;
        // bus_rvalid takes priority over a same-cycle timeout.
        if (bus_rvalid) begin
          fault_d = bus_err;
          rd_d    = bus_err ? '0 : load_extend(bus_rdata, addr_q[1:0], size_q, zext_q);
          state_d = DONE;
        end else if (timeout_c) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      zext_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
      valid_q <= (state_d == ADDR);
    end
  end

  assign dmem_rd_data = rd_q;
  assign dmem_fault   = fault_q;
  assign bus_valid    = valid_q;
  assign bus_we       = we_q;
  assign bus_addr     = {addr_q[31:2], 2'b00};
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;

  // Stall the core until DONE; forced low while reset is held.
  assign dmem_busy = dmem_req & (state_q != DONE) & ~reset;

endmodule
